word_clipper_v2: RTL and testbench
==================================

WORD_CLIPPER_V2 -- requirements
Module: word_clipper_v2

Interface
REQ-001 Parameter SAMPLE_W, default 16, signed PCM sample width.
REQ-002 Parameter FRAME_LEN, default 256, samples per analysis frame; power of two, 4..1024.
REQ-003 Parameter MAX_FRAMES, default 64, maximum frames per clipped word, 2..255.
REQ-004 Derived ENERGY_W = SAMPLE_W + clog2(FRAME_LEN); derived HANG_W = 8.
REQ-005 ACLK  in  1  sole clock; one clock domain, synchronous reset, active-low.
REQ-006 ARESETN  in  1  synchronous active-low reset, sampled on rising ACLK.
REQ-007 s_axis_tdata  in  SAMPLE_W  incoming audio sample (two's complement).
REQ-008 s_axis_tvalid  in  1 / s_axis_tready  out  1  input AXI-Stream handshake.
REQ-009 m_axis_tdata  out  SAMPLE_W  clipped word sample.
REQ-010 m_axis_tvalid  out  1 / m_axis_tready  in  1 / m_axis_tlast  out  1  output stream; tlast marks final sample of a word.
REQ-011 cfg_enable  in  1  permits word start.
REQ-012 cfg_threshold  in  ENERGY_W  frame-energy start/continue threshold.
REQ-013 cfg_hang  in  HANG_W  quiet frames tolerated before word end.
REQ-014 word_count  out  16  words completed since reset, wraps at 65535->0.
REQ-015 state_o  out  2  current FSM state encoding.

Function
REQ-016 Frame energy SHALL be sum of |sample| over FRAME_LEN accepted samples, unsigned ENERGY_W, no saturation; |most-negative| = 2^(SAMPLE_W-1).
REQ-017 Samples SHALL be written into a ping-pong buffer of 2 x FRAME_LEN entries; one half fills while the other drains.
REQ-018 Frame decision SHALL occur in the cycle the last sample of a frame is accepted; buffered frame becomes drainable (or discarded) the next cycle.
REQ-019 "Loud" frame: energy >= cfg_threshold (inclusive); otherwise "quiet".
REQ-020 FSM states IDLE(0), ACTIVE(1), HANG(2), COOLDOWN(3).
REQ-021 IDLE: quiet frame or cfg_enable=0 -> discard, stay; loud and cfg_enable=1 -> keep, go ACTIVE, frame counter=1.
REQ-022 ACTIVE: loud -> keep; quiet -> keep, go HANG, hang counter=1; if cfg_hang=0 that quiet frame is discarded and the previous kept frame's last sample carries tlast... SHALL instead: cfg_hang=0 -> quiet frame discarded, word ends with tlast asserted on an appended zero-free marker? -- resolved: cfg_hang=0 treated as 1.
REQ-023 HANG: loud -> keep, ACTIVE, hang counter cleared; quiet -> keep, hang counter+1; when hang counter reaches cfg_hang, that frame ends the word -> IDLE.
REQ-024 Kept frame count reaching MAX_FRAMES SHALL end the word on that frame and go COOLDOWN; COOLDOWN discards frames until the first quiet frame (also discarded), then IDLE.
REQ-025 Word-ending frame SHALL have m_axis_tlast=1 on its last sample only; word_count increments on that sample's output handshake.
REQ-026 Discarded frames SHALL free their buffer half in one cycle, producing no output.
REQ-027 m_axis_tdata/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-028 s_axis_tready SHALL be 0 only when the filling half is complete and the other half still holds undrained kept samples; no sample loss or duplication.
REQ-029 cfg_* SHALL be sampled only at frame decision; changes mid-frame affect the next decision.

Reset
REQ-030 ARESETN=0: FSM IDLE, accumulators, counters, buffer pointers, word_count to 0; m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0 during reset, 1 the cycle after release.
REQ-031 Reset mid-word SHALL abandon the word without tlast; buffer contents discarded.

Structure
REQ-032 Shared package word_clipper_pkg: state enum, state encodings, ENERGY_W/HANG_W derivation functions.
REQ-033 One sub-module word_clipper_pingpong_buf (dual-half sample RAM with fill/drain pointers and full flags); FSM and energy accumulator in top.

Verification (FRAME_LEN=16, MAX_FRAMES=4, cfg_threshold=1600, cfg_hang=2)
REQ-034 3 frames of +-200 between quiet frames of 0 -> one word of 5 frames (80 samples), tlast on sample 80, word_count=1.
REQ-035 All frames at +-50 -> no m_axis_tvalid ever, s_axis_tready held 1.
REQ-036 Continuous +-500 for 10 frames -> word of 4 frames with tlast, COOLDOWN until first quiet frame, word_count=1.
REQ-037 Loud word with m_axis_tready toggled 1-in-3 -> s_axis_tready drops, output samples bit-exact and ordered.
REQ-038 Samples at -32768 x16 with cfg_threshold=524288 -> frame loud (energy exactly 524288).
REQ-039 ARESETN low for 1 cycle in mid-word -> tvalid=0 next cycle, state_o=0, word_count unchanged, no tlast.

Source files
------------

// File: rtl/word_clipper_pkg.sv
// rtl/word_clipper_pkg.sv - shared state encodings and width helpers for word_clipper_v2
package word_clipper_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE     = 2'd0,
      STATE_ACTIVE   = 2'd1,
      STATE_HANG     = 2'd2,
      STATE_COOLDOWN = 2'd3
   } state_e;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ACTIVE   = 2'd1;
   localparam logic [1:0] ST_HANG     = 2'd2;
   localparam logic [1:0] ST_COOLDOWN = 2'd3;

   function automatic int energy_w(input int sample_w, input int frame_len);
      return sample_w + $clog2(frame_len);
   endfunction

   function automatic int hang_w();
      return 8;
   endfunction

endpackage

// File: rtl/word_clipper_pingpong_buf.sv
// rtl/word_clipper_pingpong_buf.sv - two-half frame buffer, one half fills while the other drains
module word_clipper_pingpong_buf #(
   parameter int SAMPLE_W  = 16,
   parameter int FRAME_LEN = 256
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wr_en,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                wr_keep,
   input  logic                wr_mark_last,
   output logic                wr_ready,
   output logic                wr_frame_end,
   output logic                rd_valid,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic                rd_last,
   input  logic                rd_ready
);
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

   logic [SAMPLE_W-1:0] mem [2*FRAME_LEN];
   logic                wr_half;
   logic                rd_half;
   logic [IDX_W-1:0]    wr_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic [1:0]          full;
   logic [1:0]          last_flag;

   assign wr_ready     = !full[wr_half];
   assign wr_frame_end = (wr_idx == IDX_LAST);
   assign rd_valid     = full[rd_half];
   assign rd_data      = mem[{rd_half, rd_idx}];
   assign rd_last      = rd_valid && last_flag[rd_half] && (rd_idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_half, wr_idx}] <= wr_data;
      end
   end

   // A discarded frame simply rewinds the fill pointer within the same half.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_half   <= 1'b0;
         rd_half   <= 1'b0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         full      <= 2'b00;
         last_flag <= 2'b00;
      end else begin
         if (wr_en) begin
            if (wr_frame_end) begin
               wr_idx <= '0;
               if (wr_keep) begin
                  full[wr_half]      <= 1'b1;
                  last_flag[wr_half] <= wr_mark_last;
                  wr_half            <= ~wr_half;
               end
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end
         if (rd_valid && rd_ready) begin
            if (rd_idx == IDX_LAST) begin
               rd_idx        <= '0;
               full[rd_half] <= 1'b0;
               rd_half       <= ~rd_half;
            end else begin
               rd_idx <= rd_idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/word_clipper_v2.sv
// rtl/word_clipper_v2.sv - energy-gated word clipper: frames audio, keeps loud runs as tlast-delimited words
module word_clipper_v2
   import word_clipper_pkg::*;
#(
   parameter int  SAMPLE_W   = 16,
   parameter int  FRAME_LEN  = 256,
   parameter int  MAX_FRAMES = 64,
   localparam int ENERGY_W   = energy_w(SAMPLE_W, FRAME_LEN),
   localparam int HANG_W     = hang_w()
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic [SAMPLE_W-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   output logic [SAMPLE_W-1:0] m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   input  logic                cfg_enable,
   input  logic [ENERGY_W-1:0] cfg_threshold,
   input  logic [HANG_W-1:0]   cfg_hang,
   output logic [15:0]         word_count,
   output logic [1:0]          state_o
);
   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [ENERGY_W-1:0] energy_acc;
   logic [ENERGY_W-1:0] energy_sum;
   logic [SAMPLE_W-1:0] magnitude;
   logic [7:0]          frames;
   logic [7:0]          frames_nxt;
   logic [7:0]          frames_inc;
   logic [HANG_W-1:0]   hang_cnt;
   logic [HANG_W-1:0]   hang_nxt;
   logic [HANG_W-1:0]   hang_lim;
   logic [HANG_W-1:0]   hang_step;
   logic                run;
   logic                s_fire;
   logic                frame_end;
   logic                frame_done;
   logic                buf_wr_ready;
   logic                loud;
   logic                keep;
   logic                mark_last;

   assign s_axis_tready = run && buf_wr_ready;
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign frame_done    = s_fire && frame_end;
   assign state_o       = state;

   assign magnitude  = s_axis_tdata[SAMPLE_W-1] ? ((~s_axis_tdata) + SAMPLE_W'(1)) : s_axis_tdata;
   assign energy_sum = energy_acc + ENERGY_W'(magnitude);
   assign loud       = (energy_sum >= cfg_threshold);
   assign hang_lim   = (cfg_hang == '0) ? HANG_W'(1) : cfg_hang;
   assign frames_inc = frames + 8'd1;
   assign hang_step  = (state == ST_ACTIVE) ? HANG_W'(1) : hang_cnt + HANG_W'(1);

   // frames counts loud frames only; the quiet hang tail does not count toward MAX_FRAMES.
   always_comb begin
      state_nxt  = state;
      frames_nxt = frames;
      hang_nxt   = hang_cnt;
      keep       = 1'b0;
      mark_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (loud && cfg_enable) begin
               keep       = 1'b1;
               state_nxt  = ST_ACTIVE;
               frames_nxt = 8'd1;
               hang_nxt   = '0;
            end
         end
         ST_ACTIVE, ST_HANG: begin
            keep = 1'b1;
            if (loud) begin
               frames_nxt = frames_inc;
               hang_nxt   = '0;
               if (frames_inc == 8'(MAX_FRAMES)) begin
                  mark_last = 1'b1;
                  state_nxt = ST_COOLDOWN;
               end else begin
                  state_nxt = ST_ACTIVE;
               end
            end else begin
               hang_nxt = hang_step;
               if (hang_step >= hang_lim) begin
                  mark_last = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_HANG;
               end
            end
         end
         default: begin
            if (!loud) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state      <= ST_IDLE;
         energy_acc <= '0;
         frames     <= '0;
         hang_cnt   <= '0;
         word_count <= '0;
         run        <= 1'b0;
      end else begin
         run <= 1'b1;
         if (s_fire) begin
            energy_acc <= frame_end ? '0 : energy_sum;
         end
         if (frame_done) begin
            state    <= state_nxt;
            frames   <= frames_nxt;
            hang_cnt <= hang_nxt;
         end
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            word_count <= word_count + 16'd1;
         end
      end
   end

   word_clipper_pingpong_buf #(
      .SAMPLE_W  (SAMPLE_W),
      .FRAME_LEN (FRAME_LEN)
   ) u_buf (
      .clk          (ACLK),
      .resetn       (ARESETN),
      .wr_en        (s_fire),
      .wr_data      (s_axis_tdata),
      .wr_keep      (keep),
      .wr_mark_last (mark_last),
      .wr_ready     (buf_wr_ready),
      .wr_frame_end (frame_end),
      .rd_valid     (m_axis_tvalid),
      .rd_data      (m_axis_tdata),
      .rd_last      (m_axis_tlast),
      .rd_ready     (m_axis_tready)
   );

endmodule

// File: tb/tb_word_clipper_v2.sv
// tb/tb_word_clipper_v2.sv - directed self-checking bench for word_clipper_v2
module tb_word_clipper_v2;
   localparam int FRAME_LEN = 16;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        cfg_enable;
   logic [19:0] cfg_threshold;
   logic [7:0]  cfg_hang;
   logic [15:0] word_count;
   logic [1:0]  state_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] got_d[$];
   logic        got_l[$];
   logic [15:0] exp_d[$];
   logic        exp_l[$];
   int          tvalid_seen = 0;
   int          tready_low = 0;
   int          unstable = 0;
   logic        hold_pending = 1'b0;
   logic [15:0] hold_d = '0;
   logic        hold_l = 1'b0;
   bit          bp_mode = 1'b0;
   int          bp_cyc = 0;

   always #5 clk = ~clk;

   word_clipper_v2 #(
      .SAMPLE_W   (16),
      .FRAME_LEN  (FRAME_LEN),
      .MAX_FRAMES (4)
   ) dut (
      .ACLK          (clk),
      .ARESETN       (resetn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .cfg_enable    (cfg_enable),
      .cfg_threshold (cfg_threshold),
      .cfg_hang      (cfg_hang),
      .word_count    (word_count),
      .state_o       (state_o)
   );

   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (m_tvalid) tvalid_seen++;
         if (!s_tready) tready_low++;
         if (hold_pending && (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l)) unstable++;
         if (m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_l.push_back(m_tlast);
         end
         hold_pending = m_tvalid && !m_tready;
         hold_d = m_tdata;
         hold_l = m_tlast;
      end else begin
         hold_pending = 1'b0;
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = bp_mode ? (bp_cyc % 3 == 0) : 1'b1;
         bp_cyc++;
      end
   end

   task automatic send_sample(input logic [15:0] v);
      int w;
      w = 0;
      s_tdata  = v;
      s_tvalid = 1'b1;
      while (s_tready !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 2000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: s_axis_tready=%b, required 1", s_tready);
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input int base, input int inc, input bit alt, input bit kept);
      for (int j = 0; j < FRAME_LEN; j++) begin
         int v;
         v = base + inc * j;
         if (alt && (j % 2 == 1)) v = -v;
         if (kept) begin
            exp_d.push_back(16'(v));
            exp_l.push_back(1'b0);
         end
         send_sample(16'(v));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      s_tvalid = 1'b0;
      resetn   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      got_d.delete();
      got_l.delete();
      exp_d.delete();
      exp_l.delete();
      tvalid_seen = 0;
      tready_low  = 0;
      unstable    = 0;
      #1 resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_drain(input int n);
      int w;
      w = 0;
      while (got_d.size() < n && w < 4000) begin
         @(negedge clk);
         w++;
      end
      repeat (20) @(negedge clk);
   endtask

   function automatic int count_bad();
      int bad;
      int n;
      bad = 0;
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b, required 0", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b, required 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %b, required 0", m_tlast); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", state_o); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0d, required 0", word_count); end
      #1 resetn = 1'b1;
      @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rel_s_tready: got %b, required 1", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rel_m_tvalid: got %b, required 0", m_tvalid); end
   endtask

   task automatic test_word();
      int bad;
      do_reset();
      send_frame(0, 0, 1'b0, 1'b0);
      repeat (3) send_frame(200, 0, 1'b1, 1'b1);
      repeat (2) send_frame(0, 0, 1'b0, 1'b1);
      send_frame(0, 0, 1'b0, 1'b0);
      s_tvalid = 1'b0;
      exp_l[79] = 1'b1;
      wait_drain(80);
      bad = count_bad();
      checks++; if (got_d.size() !== 80) begin errors++; $display("FAIL word_len: got %0d samples, required 80", got_d.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL word_data: got %0d bad samples, required 0", bad); end
      checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL word_count: got %0d, required 1", word_count); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL word_state: got %0d, required 0", state_o); end
   endtask

   task automatic test_hang_zero();
      int bad;
      do_reset();
      cfg_hang = 8'd0;
      send_frame(300, 0, 1'b1, 1'b1);
      send_frame(0, 0, 1'b0, 1'b1);
      send_frame(0, 0, 1'b0, 1'b0);
      s_tvalid = 1'b0;
      exp_l[31] = 1'b1;
      wait_drain(32);
      bad = count_bad();
      cfg_hang = 8'd2;
      checks++; if (got_d.size() !== 32) begin errors++; $display("FAIL hang0_len: got %0d samples, required 32", got_d.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL hang0_data: got %0d bad samples, required 0", bad); end
      checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL hang0_count: got %0d, required 1", word_count); end
   endtask

   task automatic test_quiet();
      do_reset();
      repeat (4) send_frame(50, 0, 1'b1, 1'b0);
      s_tvalid = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (tvalid_seen !== 0) begin errors++; $display("FAIL quiet_tvalid: got %0d valid cycles, required 0", tvalid_seen); end
      checks++; if (tready_low !== 0) begin errors++; $display("FAIL quiet_tready: got %0d stalled cycles, required 0", tready_low); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL quiet_state: got %0d, required 0", state_o); end
   endtask

   task automatic test_max_frames();
      int bad;
      do_reset();
      repeat (4) send_frame(500, 0, 1'b1, 1'b1);
      repeat (6) send_frame(500, 0, 1'b1, 1'b0);
      checks++; if (state_o !== 2'd3) begin errors++; $display("FAIL max_cooldown: got state %0d, required 3", state_o); end
      send_frame(0, 0, 1'b0, 1'b0);
      s_tvalid = 1'b0;
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL max_idle: got state %0d, required 0", state_o); end
      exp_l[63] = 1'b1;
      wait_drain(64);
      bad = count_bad();
      checks++; if (got_d.size() !== 64) begin errors++; $display("FAIL max_len: got %0d samples, required 64", got_d.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL max_data: got %0d bad samples, required 0", bad); end
      checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL max_count: got %0d, required 1", word_count); end
   endtask

   task automatic test_back_to_back();
      int bad;
      do_reset();
      bp_mode = 1'b1;
      for (int f = 0; f < 3; f++) send_frame(200 + 10 * f, 3, 1'b1, 1'b1);
      repeat (2) send_frame(0, 0, 1'b0, 1'b1);
      s_tvalid = 1'b0;
      exp_l[79] = 1'b1;
      wait_drain(80);
      bp_mode = 1'b0;
      bad = count_bad();
      checks++; if (tready_low <= 0) begin errors++; $display("FAIL bp_tready: got %0d stalled cycles, required >0", tready_low); end
      checks++; if (got_d.size() !== 80) begin errors++; $display("FAIL bp_len: got %0d samples, required 80", got_d.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_data: got %0d bad samples, required 0", bad); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles, required 0", unstable); end
      checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL bp_count: got %0d, required 1", word_count); end
   endtask

   task automatic test_neg_full();
      int bad;
      do_reset();
      cfg_threshold = 20'd524288;
      for (int j = 0; j < 15; j++) send_sample(16'h8000);
      send_sample(16'h8001);
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL neg_below: got state %0d, required 0", state_o); end
      send_frame(-32768, 0, 1'b0, 1'b1);
      s_tvalid = 1'b0;
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL neg_exact: got state %0d, required 1", state_o); end
      wait_drain(16);
      bad = count_bad();
      cfg_threshold = 20'd1600;
      checks++; if (got_d.size() !== 16) begin errors++; $display("FAIL neg_len: got %0d samples, required 16", got_d.size()); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL neg_data: got %0d bad samples, required 0", bad); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL neg_count: got %0d, required 0", word_count); end
   endtask

   task automatic test_reset_midword();
      int lasts;
      do_reset();
      send_frame(200, 0, 1'b1, 1'b1);
      for (int j = 0; j < 8; j++) send_sample(16'd400);
      s_tvalid = 1'b0;
      resetn   = 1'b0;
      @(negedge clk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b, required 0", m_tvalid); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL mid_state: got %0d, required 0", state_o); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d, required 0", word_count); end
      #1 resetn = 1'b1;
      repeat (40) @(negedge clk);
      lasts = 0;
      foreach (got_l[i]) if (got_l[i] === 1'b1) lasts++;
      checks++; if (lasts !== 0) begin errors++; $display("FAIL mid_tlast: got %0d tlast beats, required 0", lasts); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_after: got tvalid %b, required 0", m_tvalid); end
   endtask

   initial begin
      resetn        = 1'b0;
      s_tvalid      = 1'b0;
      s_tdata       = '0;
      cfg_enable    = 1'b1;
      cfg_threshold = 20'd1600;
      cfg_hang      = 8'd2;
      test_reset();
      test_word();
      test_hang_zero();
      test_quiet();
      test_max_frames();
      test_back_to_back();
      test_neg_full();
      test_reset_midword();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
